forward_stall_unit: RTL and testbench
=====================================

Name: forward_stall_unit

Overview:
Dependency tracker that sits directly upstream of the pipeline hazard controller; its STALL_OUT drives the hazard unit's STALL_IN.
It keeps a shadow copy of the destination/source fields of the ID/EXE, EXE/MEM and MEM/WB stages, updated every posedge under the hazard unit's stall/flush outputs.
It generates the forwarding-mux selects for the EXE ALU operands and the ID branch/jr comparator.
It raises multi-cycle stall requests for load-use and branch-operand dependencies.

Parameters:
REG_W, 5, register-address width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
CLOCK  in  1  single clock, all state on posedge
RESET  in  1  asynchronous, active-high; clears all state
ID_VALID  in  1  valid instruction in ID
ID_RS  in  REG_W  rs of ID instruction
ID_RT  in  REG_W  rt of ID instruction
ID_USES_RS  in  1  ID instruction reads rs
ID_USES_RT  in  1  ID instruction reads rt
ID_IS_BRANCH  in  1  branch/jr resolved in ID (operands needed in ID)
ID_DEST  in  REG_W  destination register of ID instruction
ID_WRITES  in  1  ID instruction writes ID_DEST
ID_IS_LOAD  in  1  ID instruction is a load
STALL_IDEXE  in  1  from hazard unit
FLUSH_IDEXE  in  1  from hazard unit
FLUSH_EXEMEM  in  1  from hazard unit
FLUSH_MEMWB  in  1  from hazard unit
STALL_OUT  out  1  stall request to hazard unit
FWD_A_EXE  out  2  EXE operand A select: 00 regfile, 01 EXE/MEM result, 10 MEM/WB result
FWD_B_EXE  out  2  EXE operand B select, same encoding
FWD_A_ID  out  2  ID comparator rs select, same encoding
FWD_B_ID  out  2  ID comparator rt select, same encoding
STALL_CNT  out  CNT_W  total stall cycles requested, saturating

Behaviour:
- Shadow slots: EX {rs, rt, dest, wr, load}; MEM {dest, wr, load}; WB {dest, wr}. A bubble has wr=0 and load=0.
- Reset: all slots are bubbles, FSM=IDLE, STALL_CNT=0. Reset forces all outputs to 0 immediately (async) and takes effect mid-stall.
- Posedge slot update:
  - WB <= FLUSH_MEMWB ? bubble : MEM
  - MEM <= FLUSH_EXEMEM ? bubble : EX
  - EX <= bubble if FLUSH_IDEXE, or STALL_OUT, or !ID_VALID; else EX holds if STALL_IDEXE; else EX <= ID fields.
  - Flush beats stall.
- match(slot, r) = slot.wr & (slot.dest != 0) & (slot.dest == r). Register 0 never matches, never stalls, never forwards.
- Used operand: rs counts only if ID_USES_RS; rt counts only if ID_USES_RT.
- Detection (combinational, only when ID_VALID):
  - need=1: EX.load & match(EX, used operand) (load-use).
  - need=1: ID_IS_BRANCH & !EX.load & match(EX, used operand).
  - need=1: ID_IS_BRANCH & MEM.load & match(MEM, used operand).
  - need=2: ID_IS_BRANCH & EX.load & match(EX, used operand).
  - Maximum need wins.
- FSM states: IDLE, HOLD1, HOLD2.
  - IDLE: need=2 -> HOLD1; otherwise stay (need=1 is absorbed by the bubble the stall inserts).
  - HOLD1 -> IDLE unconditionally.
  - HOLD2 unused / reserved: encoded, but it returns to IDLE.
  - STALL_OUT = (IDLE & need!=0) | HOLD1. Detection is not re-evaluated while in HOLD1.
- Timing: STALL_OUT is combinational from flops and ID inputs. It is stable before negedge, which is when the hazard unit samples it.
- STALL_CNT increments each posedge with STALL_OUT=1 and holds at all-ones.
- EXE forwarding, per operand r = EX.rs / EX.rt:
  - 01 if match(MEM, r) & !MEM.load;
  - else 10 if match(WB, r);
  - else 00.
  - MEM has priority over WB, so the youngest producer wins.
- ID forwarding uses ID_RS/ID_RT with the same rule. It is evaluated regardless of ID_IS_BRANCH.
- FLUSH_* during HOLD1: the FSM still returns to IDLE next cycle; the flushed slots become bubbles.

Test Plan:
- Load-use: lw r8 in EX, ID add reads r8 -> STALL_OUT=1 for 1 cycle, EX bubble; next cycle FWD_A_EXE=10; STALL_CNT=1.
- ALU chain: add r3 in MEM, add r3 in WB, EX reads r3 -> FWD_A_EXE=01 (MEM priority). With MEM a bubble -> 10. No stall.
- Branch after load: lw r5 in EX, beq r5,r0 in ID -> STALL_OUT high 2 consecutive cycles; then FWD_A_ID=10; STALL_CNT=2.
- Branch after ALU: add r6 in EX, jr r6 in ID -> 1 stall cycle, then FWD_A_ID=01.
- r0 dependency: lw r0 in EX, ID reads r0 -> no stall, all selects 00.
- Reset mid-stall: RESET asserted in HOLD1 -> STALL_OUT=0 immediately, STALL_CNT=0, slots cleared. After release, no spurious forwarding.

Source files
------------

// File: rtl/forward_stall_unit.sv
// forward_stall_unit
// Shadow tracker of the ID/EXE, EXE/MEM and MEM/WB destination/source fields.
// Produces forwarding-mux selects for the EXE ALU operands and the ID
// branch/jr comparator, and raises stall requests for load-use and
// branch-operand dependencies.
//
// Handshake: there is no valid/ready pair here. STALL_OUT is a level request
// that the hazard unit samples at negedge; the hazard unit answers with
// STALL_IDEXE / FLUSH_* levels that are consumed at the following posedge.
module forward_stall_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             ID_VALID,
   input  logic [REG_W-1:0] ID_RS,
   input  logic [REG_W-1:0] ID_RT,
   input  logic             ID_USES_RS,
   input  logic             ID_USES_RT,
   input  logic             ID_IS_BRANCH,
   input  logic [REG_W-1:0] ID_DEST,
   input  logic             ID_WRITES,
   input  logic             ID_IS_LOAD,
   input  logic             STALL_IDEXE,
   input  logic             FLUSH_IDEXE,
   input  logic             FLUSH_EXEMEM,
   input  logic             FLUSH_MEMWB,
   output logic             STALL_OUT,
   output logic [1:0]       FWD_A_EXE,
   output logic [1:0]       FWD_B_EXE,
   output logic [1:0]       FWD_A_ID,
   output logic [1:0]       FWD_B_ID,
   output logic [CNT_W-1:0] STALL_CNT
);

   // Forwarding-mux select encoding shared by all four selects.
   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_WB  = 2'b10;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Stall sequencer. HOLD2 is encoded but never entered; it falls back to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      HOLD1 = 2'b01,
      HOLD2 = 2'b10
   } state_t;

   state_t state;
   state_t state_nxt;

   // EX shadow slot (instruction currently in ID/EXE).
   logic [REG_W-1:0] ex_rs;
   logic [REG_W-1:0] ex_rt;
   logic [REG_W-1:0] ex_dest;
   logic             ex_wr;
   logic             ex_load;

   // MEM shadow slot (instruction currently in EXE/MEM).
   logic [REG_W-1:0] mem_dest;
   logic             mem_wr;
   logic             mem_load;

   // WB shadow slot (instruction currently in MEM/WB).
   logic [REG_W-1:0] wb_dest;
   logic             wb_wr;

   // Dependency detection terms.
   logic       ex_hit_rs;
   logic       ex_hit_rt;
   logic       mem_hit_rs;
   logic       mem_hit_rt;
   logic       dep_ex;
   logic       dep_mem;
   logic [1:0] need;
   logic       ex_kill;

   // A producer matches a register only if it writes and the register is not r0.
   function automatic logic hit(input logic             wr,
                                input logic [REG_W-1:0] dest,
                                input logic [REG_W-1:0] r);
      return wr && (dest != '0) && (dest == r);
   endfunction

   // Youngest producer wins: a non-load in MEM beats anything in WB.
   // A load in MEM has no data yet, so it never forwards from EXE/MEM.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r,
                                          input logic             m_wr,
                                          input logic [REG_W-1:0] m_dest,
                                          input logic             m_load,
                                          input logic             w_wr,
                                          input logic [REG_W-1:0] w_dest);
      if (hit(m_wr, m_dest, r) && !m_load) begin
         return SEL_MEM;
      end else if (hit(w_wr, w_dest, r)) begin
         return SEL_WB;
      end
      return SEL_RF;
   endfunction

   // Work out how many stall cycles the instruction in ID needs (0, 1 or 2).
   always_comb begin
      need       = 2'd0;
      ex_hit_rs  = ID_USES_RS && hit(ex_wr, ex_dest, ID_RS);
      ex_hit_rt  = ID_USES_RT && hit(ex_wr, ex_dest, ID_RT);
      mem_hit_rs = ID_USES_RS && hit(mem_wr, mem_dest, ID_RS);
      mem_hit_rt = ID_USES_RT && hit(mem_wr, mem_dest, ID_RT);
      dep_ex     = ex_hit_rs || ex_hit_rt;
      dep_mem    = mem_hit_rs || mem_hit_rt;
      if (ID_VALID) begin
         if (ID_IS_BRANCH && ex_load && dep_ex) begin
            // Branch needs a load result that is two stages away from ID.
            need = 2'd2;
         end else if ((ex_load && dep_ex) ||
                      (ID_IS_BRANCH && !ex_load && dep_ex) ||
                      (ID_IS_BRANCH && mem_load && dep_mem)) begin
            need = 2'd1;
         end
      end
   end

   // Stall sequencer next state and stall request. A single-cycle need is
   // covered by the bubble the stall itself inserts, so only need=2 holds.
   always_comb begin
      state_nxt = state;
      STALL_OUT = 1'b0;
      case (state)
         IDLE: begin
            STALL_OUT = (need != 2'd0);
            if (need == 2'd2) begin
               state_nxt = HOLD1;
            end
         end
         HOLD1: begin
            STALL_OUT = 1'b1;
            state_nxt = IDLE;
         end
         HOLD2: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stall sequencer state register.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The ID instruction is dropped (bubble) on flush, on our own stall, or when ID is empty.
   assign ex_kill = FLUSH_IDEXE || STALL_OUT || !ID_VALID;

   // Advance the shadow pipeline. Flush beats stall; bubbles carry all-zero fields.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_dest  <= '0;
         ex_wr    <= 1'b0;
         ex_load  <= 1'b0;
         mem_dest <= '0;
         mem_wr   <= 1'b0;
         mem_load <= 1'b0;
         wb_dest  <= '0;
         wb_wr    <= 1'b0;
      end else begin
         if (FLUSH_MEMWB) begin
            wb_dest <= '0;
            wb_wr   <= 1'b0;
         end else begin
            wb_dest <= mem_dest;
            wb_wr   <= mem_wr;
         end

         if (FLUSH_EXEMEM) begin
            mem_dest <= '0;
            mem_wr   <= 1'b0;
            mem_load <= 1'b0;
         end else begin
            mem_dest <= ex_dest;
            mem_wr   <= ex_wr;
            mem_load <= ex_load;
         end

         if (ex_kill) begin
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_dest <= '0;
            ex_wr   <= 1'b0;
            ex_load <= 1'b0;
         end else if (!STALL_IDEXE) begin
            ex_rs   <= ID_RS;
            ex_rt   <= ID_RT;
            ex_dest <= ID_DEST;
            ex_wr   <= ID_WRITES;
            ex_load <= ID_IS_LOAD;
         end
      end
   end

   // Count requested stall cycles, sticking at all-ones.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         STALL_CNT <= '0;
      end else if (STALL_OUT && (STALL_CNT != CNT_MAX)) begin
         STALL_CNT <= STALL_CNT + CNT_ONE;
      end
   end

   // Forwarding selects for the EXE operands and the ID comparator.
   always_comb begin
      FWD_A_EXE = fwd_sel(ex_rs, mem_wr, mem_dest, mem_load, wb_wr, wb_dest);
      FWD_B_EXE = fwd_sel(ex_rt, mem_wr, mem_dest, mem_load, wb_wr, wb_dest);
      FWD_A_ID  = fwd_sel(ID_RS, mem_wr, mem_dest, mem_load, wb_wr, wb_dest);
      FWD_B_ID  = fwd_sel(ID_RT, mem_wr, mem_dest, mem_load, wb_wr, wb_dest);
   end

endmodule

// File: tb/tb_forward_stall_unit.sv
// Bench for forward_stall_unit: directed scenarios with literal expectations,
// a randomized phase, and a behavioural pipeline model checked every negedge.
module tb_forward_stall_unit;

   localparam int REG_W   = 5;
   localparam int CNT_W   = 8;
   localparam int CNT_TOP = (1 << CNT_W) - 1;

   logic             CLOCK;
   logic             RESET;
   logic             ID_VALID;
   logic [REG_W-1:0] ID_RS;
   logic [REG_W-1:0] ID_RT;
   logic             ID_USES_RS;
   logic             ID_USES_RT;
   logic             ID_IS_BRANCH;
   logic [REG_W-1:0] ID_DEST;
   logic             ID_WRITES;
   logic             ID_IS_LOAD;
   logic             STALL_IDEXE;
   logic             FLUSH_IDEXE;
   logic             FLUSH_EXEMEM;
   logic             FLUSH_MEMWB;
   logic             STALL_OUT;
   logic [1:0]       FWD_A_EXE;
   logic [1:0]       FWD_B_EXE;
   logic [1:0]       FWD_A_ID;
   logic [1:0]       FWD_B_ID;
   logic [CNT_W-1:0] STALL_CNT;

   int checks = 0;
   int errors = 0;

   forward_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .ID_VALID     (ID_VALID),
      .ID_RS        (ID_RS),
      .ID_RT        (ID_RT),
      .ID_USES_RS   (ID_USES_RS),
      .ID_USES_RT   (ID_USES_RT),
      .ID_IS_BRANCH (ID_IS_BRANCH),
      .ID_DEST      (ID_DEST),
      .ID_WRITES    (ID_WRITES),
      .ID_IS_LOAD   (ID_IS_LOAD),
      .STALL_IDEXE  (STALL_IDEXE),
      .FLUSH_IDEXE  (FLUSH_IDEXE),
      .FLUSH_EXEMEM (FLUSH_EXEMEM),
      .FLUSH_MEMWB  (FLUSH_MEMWB),
      .STALL_OUT    (STALL_OUT),
      .FWD_A_EXE    (FWD_A_EXE),
      .FWD_B_EXE    (FWD_B_EXE),
      .FWD_A_ID     (FWD_A_ID),
      .FWD_B_ID     (FWD_B_ID),
      .STALL_CNT    (STALL_CNT)
   );

   // ---------------- clock / reset ----------------
   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each stage is just "the instruction sitting there"; stall length is a
   // count of extra cycles still owed after the first stall cycle.
   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dest;
      logic             wr;
      logic             load;
   } slot_t;

   slot_t m_ex, m_mem, m_wb;
   int    m_extra;
   int    m_cnt;

   function automatic bit produces(slot_t s, logic [REG_W-1:0] r);
      return s.wr && (s.dest != 0) && (s.dest == r);
   endfunction

   function automatic logic [1:0] model_fwd(logic [REG_W-1:0] r);
      if (produces(m_mem, r) && !m_mem.load) return 2'b01;
      if (produces(m_wb, r)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int model_need();
      int n;
      n = 0;
      if (!ID_VALID) return 0;
      for (int k = 0; k < 2; k++) begin
         bit               used;
         logic [REG_W-1:0] r;
         used = (k == 0) ? ID_USES_RS : ID_USES_RT;
         r    = (k == 0) ? ID_RS : ID_RT;
         if (used) begin
            if (produces(m_ex, r) && m_ex.load) n = (ID_IS_BRANCH && n < 2) ? 2 : (n < 1 ? 1 : n);
            if (ID_IS_BRANCH && produces(m_ex, r) && !m_ex.load && n < 1) n = 1;
            if (ID_IS_BRANCH && produces(m_mem, r) && m_mem.load && n < 1) n = 1;
         end
      end
      return n;
   endfunction

   // Compare process: every negedge, check all outputs, then advance the model.
   always @(negedge CLOCK) begin : cmp
      int    need;
      bit    e_stall;
      slot_t id_slot;
      if (RESET) begin
         m_ex    = '0;
         m_mem   = '0;
         m_wb    = '0;
         m_extra = 0;
         m_cnt   = 0;
      end
      need    = model_need();
      e_stall = (m_extra > 0) || (need != 0);
      chk("m_stall_out", {31'd0, STALL_OUT}, {31'd0, e_stall});
      chk("m_fwd_a_exe", {30'd0, FWD_A_EXE}, {30'd0, model_fwd(m_ex.rs)});
      chk("m_fwd_b_exe", {30'd0, FWD_B_EXE}, {30'd0, model_fwd(m_ex.rt)});
      chk("m_fwd_a_id", {30'd0, FWD_A_ID}, {30'd0, model_fwd(ID_RS)});
      chk("m_fwd_b_id", {30'd0, FWD_B_ID}, {30'd0, model_fwd(ID_RT)});
      chk("m_stall_cnt", {24'd0, STALL_CNT}, m_cnt);
      if (!RESET) begin
         if (m_extra > 0) m_extra = m_extra - 1;
         else if (need == 2) m_extra = 1;
         if (e_stall && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
         m_wb  = FLUSH_MEMWB ? '0 : m_mem;
         m_mem = FLUSH_EXEMEM ? '0 : m_ex;
         id_slot = '{rs: ID_RS, rt: ID_RT, dest: ID_DEST, wr: ID_WRITES, load: ID_IS_LOAD};
         if (FLUSH_IDEXE || e_stall || !ID_VALID) m_ex = '0;
         else if (!STALL_IDEXE) m_ex = id_slot;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit br, input int dest, input bit wr, input bit ld);
      ID_VALID     = v;
      ID_RS        = REG_W'(rs);
      ID_RT        = REG_W'(rt);
      ID_USES_RS   = urs;
      ID_USES_RT   = urt;
      ID_IS_BRANCH = br;
      ID_DEST      = REG_W'(dest);
      ID_WRITES    = wr;
      ID_IS_LOAD   = ld;
      STALL_IDEXE  = 1'b0;
      FLUSH_IDEXE  = 1'b0;
      FLUSH_EXEMEM = 1'b0;
      FLUSH_MEMWB  = 1'b0;
   endtask

   task automatic set_idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drive_random();
      ID_VALID     = ($urandom_range(0, 9) != 0);
      ID_RS        = REG_W'($urandom_range(0, 3));
      ID_RT        = REG_W'($urandom_range(0, 3));
      ID_USES_RS   = ($urandom_range(0, 3) != 0);
      ID_USES_RT   = ($urandom_range(0, 3) != 0);
      ID_IS_BRANCH = ($urandom_range(0, 2) == 0);
      ID_DEST      = REG_W'($urandom_range(0, 3));
      ID_WRITES    = ($urandom_range(0, 3) != 0);
      ID_IS_LOAD   = ($urandom_range(0, 1) == 0);
      STALL_IDEXE  = ($urandom_range(0, 7) == 0);
      FLUSH_IDEXE  = ($urandom_range(0, 15) == 0);
      FLUSH_EXEMEM = ($urandom_range(0, 15) == 0);
      FLUSH_MEMWB  = ($urandom_range(0, 15) == 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RESET = 1'b1;
      set_idle();
      tick();
      #1;
      chk("rst_stall_out", {31'd0, STALL_OUT}, 32'd0);
      chk("rst_stall_cnt", {24'd0, STALL_CNT}, 32'd0);
      chk("rst_fwd_a_exe", {30'd0, FWD_A_EXE}, 32'd0);

      // Load-use: lw r8 then add reading r8.
      do_reset();
      set_id(1, 1, 0, 1, 0, 0, 8, 1, 1);
      tick();
      set_id(1, 8, 2, 1, 1, 0, 9, 1, 0);
      @(negedge CLOCK);
      chk("lu_stall", {31'd0, STALL_OUT}, 32'd1);
      tick();
      @(negedge CLOCK);
      chk("lu_release", {31'd0, STALL_OUT}, 32'd0);
      chk("lu_bubble_fwd", {30'd0, FWD_A_EXE}, 32'd0);
      tick();
      set_idle();
      @(negedge CLOCK);
      chk("lu_fwd_a_exe", {30'd0, FWD_A_EXE}, 32'd2);
      chk("lu_cnt", {24'd0, STALL_CNT}, 32'd1);
      tick();

      // ALU chain: r3 produced in MEM and WB, consumer in EX.
      do_reset();
      set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
      tick();
      tick();
      set_id(1, 3, 4, 1, 1, 0, 7, 1, 0);
      @(negedge CLOCK);
      chk("alu_no_stall", {31'd0, STALL_OUT}, 32'd0);
      tick();
      set_idle();
      @(negedge CLOCK);
      chk("alu_mem_prio", {30'd0, FWD_A_EXE}, 32'd1);
      tick();
      do_reset();
      set_id(1, 1, 2, 1, 1, 0, 3, 1, 0);
      tick();
      set_idle();
      tick();
      set_id(1, 3, 4, 1, 1, 0, 7, 1, 0);
      tick();
      set_idle();
      @(negedge CLOCK);
      chk("alu_wb_fwd", {30'd0, FWD_A_EXE}, 32'd2);
      chk("alu_b_none", {30'd0, FWD_B_EXE}, 32'd0);
      tick();

      // Branch after load: two stall cycles, then forward from WB.
      do_reset();
      set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
      tick();
      set_id(1, 5, 0, 1, 1, 1, 0, 0, 0);
      @(negedge CLOCK);
      chk("bl_stall1", {31'd0, STALL_OUT}, 32'd1);
      tick();
      @(negedge CLOCK);
      chk("bl_stall2", {31'd0, STALL_OUT}, 32'd1);
      tick();
      @(negedge CLOCK);
      chk("bl_release", {31'd0, STALL_OUT}, 32'd0);
      chk("bl_fwd_a_id", {30'd0, FWD_A_ID}, 32'd2);
      chk("bl_fwd_b_id", {30'd0, FWD_B_ID}, 32'd0);
      chk("bl_cnt", {24'd0, STALL_CNT}, 32'd2);
      tick();

      // Branch after ALU: one stall, then forward from MEM.
      do_reset();
      set_id(1, 1, 2, 1, 1, 0, 6, 1, 0);
      tick();
      set_id(1, 6, 0, 1, 0, 1, 0, 0, 0);
      @(negedge CLOCK);
      chk("ba_stall", {31'd0, STALL_OUT}, 32'd1);
      tick();
      @(negedge CLOCK);
      chk("ba_release", {31'd0, STALL_OUT}, 32'd0);
      chk("ba_fwd_a_id", {30'd0, FWD_A_ID}, 32'd1);
      chk("ba_cnt", {24'd0, STALL_CNT}, 32'd1);
      tick();

      // r0 dependency never stalls or forwards.
      do_reset();
      set_id(1, 1, 0, 1, 0, 0, 0, 1, 1);
      tick();
      set_id(1, 0, 0, 1, 1, 1, 0, 0, 0);
      @(negedge CLOCK);
      chk("r0_stall", {31'd0, STALL_OUT}, 32'd0);
      chk("r0_fwd_a_id", {30'd0, FWD_A_ID}, 32'd0);
      chk("r0_fwd_b_id", {30'd0, FWD_B_ID}, 32'd0);
      tick();
      set_idle();
      @(negedge CLOCK);
      chk("r0_fwd_a_exe", {30'd0, FWD_A_EXE}, 32'd0);
      chk("r0_cnt", {24'd0, STALL_CNT}, 32'd0);
      tick();

      // Reset asserted while the second stall cycle is in progress.
      do_reset();
      set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
      tick();
      set_id(1, 5, 0, 1, 1, 1, 0, 0, 0);
      @(negedge CLOCK);
      chk("rm_stall1", {31'd0, STALL_OUT}, 32'd1);
      tick();
      RESET = 1'b1;
      #1;
      chk("rm_stall_async", {31'd0, STALL_OUT}, 32'd0);
      chk("rm_cnt_async", {24'd0, STALL_CNT}, 32'd0);
      chk("rm_fwd_a_id", {30'd0, FWD_A_ID}, 32'd0);
      tick();
      RESET = 1'b0;
      @(negedge CLOCK);
      chk("rm_post_stall", {31'd0, STALL_OUT}, 32'd0);
      chk("rm_post_fwd_id", {30'd0, FWD_A_ID}, 32'd0);
      tick();
      set_idle();
      @(negedge CLOCK);
      chk("rm_post_fwd_exe", {30'd0, FWD_A_EXE}, 32'd0);
      chk("rm_post_cnt", {24'd0, STALL_CNT}, 32'd0);
      tick();

      // Randomized traffic, checked by the model every cycle.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         drive_random();
         tick();
      end

      // Saturation: each lw/beq pair requests two stall cycles.
      for (int i = 0; i < 140; i++) begin
         set_id(1, 1, 0, 1, 0, 0, 5, 1, 1);
         tick();
         set_id(1, 5, 0, 1, 1, 1, 0, 0, 0);
         tick();
         tick();
         tick();
      end
      set_idle();
      @(negedge CLOCK);
      chk("cnt_saturated", {24'd0, STALL_CNT}, 32'd255);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
